// File: rtl/mem_arbiter_if.sv
// Core-side fetch/load-store ports and the memory port of the arbiter.
// slave = arbiter view; master = core + memory instance view.
interface mem_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_err_o;

    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        d_err_o;

    logic        mem_wen_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output mem_wen_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  mem_wen_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch vs load/store arbiter for a single-port 512x32 memory.
// Sub-word stores become a two-cycle read-modify-write.
module mem_arbiter #(
    parameter int MEM_WORDS = 512
) (
    input logic          clk_i,
    input logic          rst_ni,
    mem_arbiter_if.slave bus
);

    typedef enum logic {
        S_IDLE,
        S_RMW
    } state_t;

    typedef enum logic {
        RR_DATA,
        RR_FETCH
    } rr_t;

    localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

    state_t      r_state;
    state_t      w_state_nxt;
    rr_t         r_rr;
    rr_t         w_rr_nxt;
    logic [31:0] r_old;
    logic [31:0] w_old_nxt;

    logic        r_if_rvalid;
    logic        r_if_err;
    logic [31:0] r_if_rdata;
    logic        r_d_rvalid;
    logic        r_d_err;
    logic [31:0] r_d_rdata;

    logic        w_if_err;
    logic        w_d_err;
    logic        w_both;
    logic        w_pick_d;
    logic        w_pick_i;
    logic        w_d_ld;
    logic        w_d_st_full;
    logic        w_d_st_none;
    logic        w_d_st_part;
    logic [31:0] w_mask;
    logic [31:0] w_merge;

    logic        w_if_gnt;
    logic        w_d_gnt;
    logic        w_if_rd;
    logic        w_d_rd;
    logic        w_mem_wen;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;

    assign w_if_err = (bus.if_addr_i[1:0] != 2'b00)
                    || (bus.if_addr_i[31:2] >= LP_WORDS);
    assign w_d_err  = (bus.d_addr_i[1:0] != 2'b00)
                    || (bus.d_addr_i[31:2] >= LP_WORDS);

    assign w_both   = bus.if_req_i && bus.d_req_i;
    assign w_pick_d = bus.d_req_i
                    && (!bus.if_req_i || (r_rr == RR_DATA));
    assign w_pick_i = bus.if_req_i && !w_pick_d;

    // Exactly one of these holds for a picked data request.
    assign w_d_ld      = !w_d_err && !bus.d_we_i;
    assign w_d_st_full = !w_d_err && bus.d_we_i
                       && (bus.d_be_i == 4'b1111);
    assign w_d_st_none = !w_d_err && bus.d_we_i
                       && (bus.d_be_i == 4'b0000);
    assign w_d_st_part = !w_d_err && bus.d_we_i
                       && (bus.d_be_i != 4'b1111)
                       && (bus.d_be_i != 4'b0000);

    assign w_mask = {
        {8{bus.d_be_i[3]}},
        {8{bus.d_be_i[2]}},
        {8{bus.d_be_i[1]}},
        {8{bus.d_be_i[0]}}
    };
    assign w_merge = (r_old & ~w_mask)
                   | (bus.d_wdata_i & w_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_old_nxt   = r_old;
        w_if_gnt    = 1'b0;
        w_d_gnt     = 1'b0;
        w_if_rd     = 1'b0;
        w_d_rd      = 1'b0;
        w_mem_wen   = 1'b0;
        w_mem_addr  = 32'h0;
        w_mem_wdata = 32'h0;
        // Reset also kills an in-flight RMW write.
        if (rst_ni) begin
            unique case (r_state)
                S_RMW: begin
                    w_d_gnt     = 1'b1;
                    w_mem_wen   = 1'b1;
                    w_mem_addr  = bus.d_addr_i;
                    w_mem_wdata = w_merge;
                    w_state_nxt = S_IDLE;
                end
                S_IDLE: begin
                    if (w_pick_i) begin
                        w_if_gnt = 1'b1;
                        if (!w_if_err) begin
                            w_mem_addr = bus.if_addr_i;
                            w_if_rd    = 1'b1;
                        end
                    end else if (w_pick_d) begin
                        unique case (1'b1)
                            w_d_err: begin
                                w_d_gnt = 1'b1;
                            end
                            w_d_ld: begin
                                w_d_gnt    = 1'b1;
                                w_d_rd     = 1'b1;
                                w_mem_addr = bus.d_addr_i;
                            end
                            w_d_st_full: begin
                                w_d_gnt     = 1'b1;
                                w_mem_wen   = 1'b1;
                                w_mem_addr  = bus.d_addr_i;
                                w_mem_wdata = bus.d_wdata_i;
                            end
                            w_d_st_none: begin
                                w_d_gnt = 1'b1;
                            end
                            w_d_st_part: begin
                                w_mem_addr  = bus.d_addr_i;
                                w_old_nxt   = bus.mem_rdata_i;
                                w_state_nxt = S_RMW;
                            end
                        endcase
                    end
                end
            endcase
            if ((w_if_gnt || w_d_gnt) && w_both) begin
                w_rr_nxt = (r_rr == RR_DATA) ? RR_FETCH : RR_DATA;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_rr        <= RR_DATA;
            r_old       <= 32'h0;
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_d_rvalid  <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr        <= w_rr_nxt;
            r_old       <= w_old_nxt;
            r_if_rvalid <= w_if_gnt;
            r_if_err    <= w_if_gnt && w_if_err;
            r_if_rdata  <= w_if_rd ? bus.mem_rdata_i : 32'h0;
            r_d_rvalid  <= w_d_gnt;
            r_d_err     <= w_d_gnt && w_d_err;
            r_d_rdata   <= w_d_rd ? bus.mem_rdata_i : 32'h0;
        end
    end

    assign bus.if_gnt_o    = w_if_gnt;
    assign bus.if_rvalid_o = r_if_rvalid;
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.if_err_o    = r_if_err;
    assign bus.d_gnt_o     = w_d_gnt;
    assign bus.d_rvalid_o  = r_d_rvalid;
    assign bus.d_rdata_o   = r_d_rdata;
    assign bus.d_err_o     = r_d_err;
    assign bus.mem_wen_o   = w_mem_wen;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = w_mem_wdata;

    a_one_gnt: assert property (
        @(posedge clk_i) !(w_if_gnt && w_d_gnt)
    );
    a_wen_gnt: assert property (
        @(posedge clk_i) w_mem_wen |-> w_d_gnt
    );

endmodule
